// File: rtl/frame_deformer.sv
// frame_deformer: hunts a serial bit stream for a sync word, then forwards
// PAYLOAD_LEN bits per frame from the input bit FIFO to the output bit FIFO.
// Ports: CLK, RESET_N (async, active low)
//        FIFO_IN_DATA/RE/EMPTY  - input bit FIFO, data valid cycle after RE
//        FIFO_OUT_DATA/WE/FULL  - output bit FIFO
//        SYNC_LOCK   - high while forwarding payload
//        FRAME_START - one-cycle pulse on sync word match
//        FRAME_CNT   - completed frames, wraps
// Macro DEFRAMER_ERR_TOL_EN: accept up to PREAMBLE_MAX_ERR bit errors in
// the sync word; undefined means exact match only.
module frame_deformer #(
  parameter int PREAMBLE_LEN = 30,
  parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_VAL = 'h0123425,
  parameter int PAYLOAD_LEN = 48,
  parameter int PREAMBLE_MAX_ERR = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        FIFO_IN_DATA,
  output logic        FIFO_IN_RE,
  input  logic        FIFO_IN_EMPTY,
  output logic        FIFO_OUT_DATA,
  output logic        FIFO_OUT_WE,
  input  logic        FIFO_OUT_FULL,
  output logic        SYNC_LOCK,
  output logic        FRAME_START,
  output logic [15:0] FRAME_CNT
);

  localparam int FW = $clog2(PREAMBLE_LEN + 1);
  localparam int PW = (PAYLOAD_LEN > 1) ?
                      $clog2(PAYLOAD_LEN) : 1;
  localparam logic [FW-1:0] FILL_FULL = FW'(PREAMBLE_LEN);
  localparam logic [PW-1:0] PAY_LAST = PW'(PAYLOAD_LEN - 1);

  // A tolerance of half the word or more would accept garbage.
  if (PREAMBLE_MAX_ERR >= PREAMBLE_LEN / 2) begin : g_bad_cfg
    $error("PREAMBLE_MAX_ERR too large");
  end

  typedef enum logic [2:0] {
    WAIT_FIFO_IN,
    READ_FROM_FIFO_IN,
    GET_FROM_FIFO_IN,
    CHECK_SYNC,
    CHECK_FIFO_OUT_DATA,
    SEND_DATA
  } state_t;

  typedef enum logic {
    HUNT,
    PAYLOAD
  } mode_t;

  state_t state;
  state_t state_nxt;
  mode_t  mode;

  logic [PREAMBLE_LEN-1:0] window;
  logic [FW-1:0]           fill_cnt;
  logic [PW-1:0]           pay_cnt;
  logic                    data_int;
  logic                    win_ok;
  logic                    match;

`ifdef DEFRAMER_ERR_TOL_EN
  logic [PREAMBLE_LEN-1:0] diff;
  logic [FW-1:0]           dist;

  always_comb begin
    diff = window ^ PREAMBLE_VAL;
    dist = '0;
    for (int i = 0; i < PREAMBLE_LEN; i++) begin
      dist = dist + FW'(diff[i]);
    end
  end

  assign win_ok = (dist <= FW'(PREAMBLE_MAX_ERR));
`else
  assign win_ok = (window == PREAMBLE_VAL);
`endif

  // Only a fully refilled window may match, so bits left over from
  // a previous frame never combine into a false sync.
  assign match = (fill_cnt == FILL_FULL) && win_ok;

  assign SYNC_LOCK = (mode == PAYLOAD);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= WAIT_FIFO_IN;
      mode      <= HUNT;
      window    <= '0;
      fill_cnt  <= '0;
      pay_cnt   <= '0;
      data_int  <= 1'b0;
      FRAME_CNT <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        GET_FROM_FIFO_IN: begin
          data_int <= FIFO_IN_DATA;
          if (mode == HUNT) begin
            window <= {FIFO_IN_DATA,
                       window[PREAMBLE_LEN-1:1]};
            if (fill_cnt != FILL_FULL) begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        CHECK_SYNC: begin
          if (match) begin
            mode    <= PAYLOAD;
            pay_cnt <= '0;
          end
        end
        SEND_DATA: begin
          if (pay_cnt == PAY_LAST) begin
            mode      <= HUNT;
            pay_cnt   <= '0;
            window    <= '0;
            fill_cnt  <= '0;
            FRAME_CNT <= FRAME_CNT + 16'd1;
          end else begin
            pay_cnt <= pay_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    FIFO_IN_RE    = 1'b0;
    FIFO_OUT_WE   = 1'b0;
    FIFO_OUT_DATA = 1'b0;
    FRAME_START   = 1'b0;
    unique case (state)
      WAIT_FIFO_IN: begin
        if (!FIFO_IN_EMPTY) begin
          state_nxt = READ_FROM_FIFO_IN;
        end
      end
      READ_FROM_FIFO_IN: begin
        FIFO_IN_RE = 1'b1;
        state_nxt  = GET_FROM_FIFO_IN;
      end
      GET_FROM_FIFO_IN: begin
        state_nxt = (mode == HUNT) ? CHECK_SYNC :
                    CHECK_FIFO_OUT_DATA;
      end
      CHECK_SYNC: begin
        FRAME_START = match;
        state_nxt   = WAIT_FIFO_IN;
      end
      CHECK_FIFO_OUT_DATA: begin
        if (!FIFO_OUT_FULL) begin
          state_nxt = SEND_DATA;
        end
      end
      SEND_DATA: begin
        FIFO_OUT_WE   = 1'b1;
        FIFO_OUT_DATA = data_int;
        state_nxt     = WAIT_FIFO_IN;
      end
      default: begin
        state_nxt = WAIT_FIFO_IN;
      end
    endcase
  end

endmodule

// File: tb/tb_frame_deformer.sv
// tb_frame_deformer: bit-FIFO models around frame_deformer, table of
// frames plus hand-written backpressure, reset and back-to-back cases.
module tb_frame_deformer;

  localparam logic [29:0] PRE = 30'h0123425;
  localparam logic [29:0] PRE_ERR = 30'h0123425 ^ 30'h0020008;
`ifdef DEFRAMER_ERR_TOL_EN
  localparam int ERR_WR = 48;
`else
  localparam int ERR_WR = 0;
`endif

  logic        CLK;
  logic        RESET_N;
  logic        FIFO_IN_DATA;
  logic        FIFO_IN_RE;
  logic        FIFO_IN_EMPTY;
  logic        FIFO_OUT_DATA;
  logic        FIFO_OUT_WE;
  logic        FIFO_OUT_FULL;
  logic        SYNC_LOCK;
  logic        FRAME_START;
  logic [15:0] FRAME_CNT;

  frame_deformer dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .FIFO_IN_DATA (FIFO_IN_DATA),
    .FIFO_IN_RE   (FIFO_IN_RE),
    .FIFO_IN_EMPTY(FIFO_IN_EMPTY),
    .FIFO_OUT_DATA(FIFO_OUT_DATA),
    .FIFO_OUT_WE  (FIFO_OUT_WE),
    .FIFO_OUT_FULL(FIFO_OUT_FULL),
    .SYNC_LOCK    (SYNC_LOCK),
    .FRAME_START  (FRAME_START),
    .FRAME_CNT    (FRAME_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Input bit FIFO model.
  logic stream [0:4095];
  int   wr_ptr = 0;
  int   rd_ptr = 0;

  assign FIFO_IN_EMPTY = (rd_ptr == wr_ptr);

  always @(posedge CLK) begin
    if (FIFO_IN_RE && rd_ptr != wr_ptr) begin
      FIFO_IN_DATA <= stream[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Output bit FIFO model and event monitors.
  logic out_bits [0:4095];
  int   out_cnt = 0;
  int   fs_cnt = 0;
  int   re_cnt = 0;
  int   we_full = 0;
  int   re_full = 0;
  int   dnz = 0;

  always @(posedge CLK) begin
    if (FIFO_OUT_WE) begin
      out_bits[out_cnt] <= FIFO_OUT_DATA;
      out_cnt           <= out_cnt + 1;
    end
    if (FRAME_START) fs_cnt <= fs_cnt + 1;
    if (FIFO_IN_RE) re_cnt <= re_cnt + 1;
    if (FIFO_OUT_FULL && FIFO_OUT_WE) we_full <= we_full + 1;
    if (FIFO_OUT_FULL && FIFO_IN_RE) re_full <= re_full + 1;
    if (!FIFO_OUT_WE && FIFO_OUT_DATA) dnz <= dnz + 1;
  end

  int checks = 0;
  int failures = 0;
  int exp_fcnt = 0;

  typedef struct {
    int          garbage;
    logic [29:0] pre;
    logic [47:0] pay;
    int          exp_wr;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h",
               name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      stream[wr_ptr] = v[i];
      wr_ptr++;
    end
  endtask

  function automatic logic [47:0] got_pay(input int base);
    logic [47:0] g;
    for (int i = 0; i < 48; i++) g[i] = out_bits[base + i];
    return g;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while (rd_ptr != wr_ptr && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    check(name, 64'(rd_ptr == wr_ptr), 64'd1);
    repeat (12) @(negedge CLK);
  endtask

  task automatic wait_writes(input int target,
                             input string name);
    int n;
    n = 0;
    while (out_cnt < target && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    check(name, 64'(out_cnt >= target), 64'd1);
  endtask

  initial begin
    int base;
    int fs0;
    int c0;
    int w0;
    int r0;
    logic [47:0] pay;
    logic [47:0] pay2;

    vecs[0] = '{0,  PRE,     48'hA5A5_1234_5678, 48};
    vecs[1] = '{17, PRE,     48'hA5A5_1234_5678, 48};
    vecs[2] = '{0,  PRE,     48'h0000_0000_0000, 48};
    vecs[3] = '{0,  PRE_ERR, 48'hA5A5_1234_5678, ERR_WR};
    vecs[4] = '{5,  PRE,     48'hFFFF_FFFF_FFFF, 48};

    FIFO_OUT_FULL = 1'b0;
    RESET_N = 1'b1;
    #1 RESET_N = 1'b0;
    #1;
    check("rst_re", 64'(FIFO_IN_RE), 64'd0);
    check("rst_we", 64'(FIFO_OUT_WE), 64'd0);
    check("rst_data", 64'(FIFO_OUT_DATA), 64'd0);
    check("rst_lock", 64'(SYNC_LOCK), 64'd0);
    check("rst_fs", 64'(FRAME_START), 64'd0);
    check("rst_fcnt", 64'(FRAME_CNT), 64'd0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;

    repeat (20) @(negedge CLK);
    check("idle_no_read", 64'(re_cnt), 64'd0);

    for (int v = 0; v < 5; v++) begin
      base = out_cnt;
      fs0  = fs_cnt;
      push(64'h1B2C5, vecs[v].garbage);
      push(64'(vecs[v].pre), 30);
      push(64'(vecs[v].pay), 48);
      drain("vec_drain");
      check($sformatf("vec%0d_writes", v),
            64'(out_cnt - base), 64'(vecs[v].exp_wr));
      if (vecs[v].exp_wr == 48) begin
        check($sformatf("vec%0d_payload", v),
              64'(got_pay(base)), 64'(vecs[v].pay));
      end
      check($sformatf("vec%0d_fs", v),
            64'(fs_cnt - fs0), 64'(vecs[v].exp_wr / 48));
      exp_fcnt += vecs[v].exp_wr / 48;
      check($sformatf("vec%0d_fcnt", v),
            64'(FRAME_CNT), 64'(exp_fcnt));
      check($sformatf("vec%0d_lock", v),
            64'(SYNC_LOCK), 64'd0);
    end

    // Backpressure at payload bit 10.
    pay  = 48'h5A5A_F00D_C3C3;
    base = out_cnt;
    fs0  = fs_cnt;
    push(64'(PRE), 30);
    push(64'(pay), 48);
    wait_writes(base + 10, "bp_wait");
    FIFO_OUT_FULL = 1'b1;
    c0 = out_cnt;
    w0 = we_full;
    r0 = re_full;
    repeat (20) @(negedge CLK);
    check("bp_hold", 64'(out_cnt - c0), 64'd0);
    check("bp_we", 64'(we_full - w0), 64'd0);
    check("bp_reads_le1", 64'((re_full - r0) <= 1), 64'd1);
    FIFO_OUT_FULL = 1'b0;
    drain("bp_drain");
    check("bp_writes", 64'(out_cnt - base), 64'd48);
    check("bp_payload", 64'(got_pay(base)), 64'(pay));
    check("bp_fs", 64'(fs_cnt - fs0), 64'd1);
    exp_fcnt++;
    check("bp_fcnt", 64'(FRAME_CNT), 64'(exp_fcnt));

    // Asynchronous reset at payload bit 20.
    pay  = 48'h0F1E_2D3C_4B5A;
    base = out_cnt;
    push(64'(PRE), 30);
    push(64'(pay), 48);
    wait_writes(base + 20, "rst_wait");
    check("lock_mid", 64'(SYNC_LOCK), 64'd1);
    #2 RESET_N = 1'b0;
    #1;
    check("mrst_re", 64'(FIFO_IN_RE), 64'd0);
    check("mrst_we", 64'(FIFO_OUT_WE), 64'd0);
    check("mrst_data", 64'(FIFO_OUT_DATA), 64'd0);
    check("mrst_lock", 64'(SYNC_LOCK), 64'd0);
    check("mrst_fcnt", 64'(FRAME_CNT), 64'd0);
    exp_fcnt = 0;
    wr_ptr = rd_ptr;
    repeat (2) @(negedge CLK);
    #3 RESET_N = 1'b1;
    base = out_cnt;
    push(64'(pay >> 20), 28);
    drain("rst_tail_drain");
    check("rst_nowrite", 64'(out_cnt - base), 64'd0);
    check("rst_nolock", 64'(SYNC_LOCK), 64'd0);
    base = out_cnt;
    push(64'(PRE), 30);
    push(64'(pay), 48);
    drain("rst_new_drain");
    check("rst_new_writes", 64'(out_cnt - base), 64'd48);
    check("rst_new_payload", 64'(got_pay(base)), 64'(pay));
    exp_fcnt++;
    check("rst_new_fcnt", 64'(FRAME_CNT), 64'(exp_fcnt));

    // Back-to-back frames, first payload carries the sync word.
    pay  = {18'h2B3C5, PRE};
    pay2 = 48'hDEAD_BEEF_0042;
    base = out_cnt;
    fs0  = fs_cnt;
    push(64'(PRE), 30);
    push(64'(pay), 48);
    push(64'(PRE), 30);
    push(64'(pay2), 48);
    drain("b2b_drain");
    check("b2b_writes", 64'(out_cnt - base), 64'd96);
    check("b2b_pay1", 64'(got_pay(base)), 64'(pay));
    check("b2b_pay2", 64'(got_pay(base + 48)), 64'(pay2));
    check("b2b_fs", 64'(fs_cnt - fs0), 64'd2);
    exp_fcnt += 2;
    check("b2b_fcnt", 64'(FRAME_CNT), 64'(exp_fcnt));
    check("b2b_lock", 64'(SYNC_LOCK), 64'd0);

    check("data_zero_idle", 64'(dnz), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
